// File: rtl/div_ctrl_if.sv
// Handshake and result bundle between the EX stage (master) and the iterative
// divider (slave).
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic             annul;
    logic             stall_req;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  stall_req, busy, ready, div_by_zero, result_hi, result_lo
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output stall_req, busy, ready, div_by_zero, result_hi, result_lo
    );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, sign fix-up folded into the result load, HI = remainder, LO = quotient.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_ctrl_if.slave       bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVZERO,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             divisor_zero;
    logic             last_step;
    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_ok;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign accept       = (state_q == ST_IDLE) && bus.start && !bus.annul;
    assign divisor_zero = (bus.opdata2 == '0);
    assign last_step    = (cnt_q == CW'(WIDTH - 1));

    assign op1_neg = bus.signed_div & bus.opdata1[WIDTH-1];
    assign op2_neg = bus.signed_div & bus.opdata2[WIDTH-1];
    assign op1_mag = op1_neg ? -bus.opdata1 : bus.opdata1;
    assign op2_mag = op2_neg ? -bus.opdata2 : bus.opdata2;

    // rem < divisor always holds, so the shifted partial remainder is below
    // 2*divisor and the top bit of the WIDTH+1 bit difference is a true sign.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign trial_ok = ~trial[WIDTH];
    assign step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], trial_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = divisor_zero ? ST_DIVZERO : ST_RUN;
                end
            end
            ST_DIVZERO: begin
                state_d = bus.annul ? ST_IDLE : ST_DONE;
            end
            ST_RUN: begin
                if (bus.annul) begin
                    state_d = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are loaded on the edge entering DONE so they are already visible
    // during the ready cycle; an annulled operation never reaches this load.
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvs_d   = op2_mag;
                    quo_d   = divisor_zero ? bus.opdata1 : op1_mag;
                    q_neg_d = op1_neg ^ op2_neg;
                    r_neg_d = op1_neg;
                end
            end
            ST_DIVZERO: begin
                if (!bus.annul) begin
                    res_lo_d = '1;
                    res_hi_d = quo_q;
                    dbz_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.annul) begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        res_lo_d = q_neg_q ? -step_quo : step_quo;
                        res_hi_d = r_neg_q ? -step_rem : step_rem;
                        dbz_d    = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.stall_req   = accept || (state_q == ST_DIVZERO) || (state_q == ST_RUN);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ready       = (state_q == ST_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.result_lo   = res_lo_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: hand-computed quotients/remainders, latency,
// stall behaviour, flush, reset and start-while-busy disturbances.
module tb_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation. disturb=1 pulses start with junk operands during RUN.
    task automatic do_div(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_dbz, input logic disturb);
        int   lat;
        logic stall_ok;
        @(negedge clk);
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        bus.signed_div = sg;
        bus.opdata1    = a;
        bus.opdata2    = b;
        #1 check({name, "_stall_at_start"}, 32'(bus.stall_req), 32'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.opdata1 = 32'hDEAD_BEEF;
        bus.opdata2 = 32'h0000_0003;
        lat = 0;
        stall_ok = 1'b1;
        while (!bus.ready && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!bus.ready && !bus.stall_req) stall_ok = 1'b0;
            if (disturb && (lat == 5 || lat == 15)) begin
                bus.start   = 1'b1;
                bus.opdata1 = 32'd77;
                bus.opdata2 = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_stall_while_running"}, 32'(stall_ok), 32'd1);
        check({name, "_stall_in_done"}, 32'(bus.stall_req), 32'd0);
        check({name, "_lo"}, bus.result_lo, exp_lo);
        check({name, "_hi"}, bus.result_hi, exp_hi);
        check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        $display("op %-10s a=%h b=%h lat=%0d lo=%h hi=%h dbz=%0b",
                 name, a, b, lat, bus.result_lo, bus.result_hi, bus.div_by_zero);
        @(negedge clk);
        check({name, "_idle_after_done"}, 32'(bus.busy), 32'd0);
        check({name, "_ready_pulse_one_cycle"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_stall", 32'(bus.stall_req), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        check("reset_lo", bus.result_lo, 32'd0);
        check("reset_hi", bus.result_hi, 32'd0);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        do_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
        do_div("divu_z", 1'b0, 32'h0000_1234, 32'd0, 2, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
        do_div("div_z_neg", 1'b1, 32'hFFFF_FFF0, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
        do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);

        // start together with annul in IDLE is dropped
        @(negedge clk);
        bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5;
        #1 check("annul_idle_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.annul = 1'b0;
        check("annul_idle_busy", 32'(bus.busy), 32'd0);

        // flush at RUN cycle 10: back to IDLE, no ready, previous results kept
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'h0000_FFFF; bus.opdata2 = 32'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("annul_run_busy_before", 32'(bus.busy), 32'd1);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul_run_busy", 32'(bus.busy), 32'd0);
        check("annul_run_ready", 32'(bus.ready), 32'd0);
        check("annul_run_lo_kept", bus.result_lo, 32'hFFFF_FFF2);
        check("annul_run_hi_kept", bus.result_hi, 32'd2);
        $display("op annul      busy=%0b lo=%h hi=%h", bus.busy, bus.result_lo, bus.result_hi);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, 1'b0);

        // start pulses during RUN are ignored
        do_div("divu_dist", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0, 1'b0, 1'b1);

        // asynchronous reset mid-RUN, with div_by_zero and results non-zero beforehand
        do_div("divu_z2", 1'b0, 32'h0000_0055, 32'd0, 2, 32'hFFFF_FFFF, 32'h0000_0055, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall_req), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_lo", bus.result_lo, 32'd0);
        check("rst_hi", bus.result_hi, 32'd0);
        $display("op reset      busy=%0b lo=%h hi=%h", bus.busy, bus.result_lo, bus.result_hi);
        @(negedge clk);
        rst = 1'b0;
        do_div("divu_post_rst", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
